// File: rtl/seg_mtr_drv.sv
// Dual H-bridge PWM driver with complementary gates, fixed non-overlap and a latched
// over-current fault. Define OVR_FAULT_EN to compile in over-current detection and the fault FSM.
module seg_mtr_drv #(
  parameter int unsigned DEADTIME  = 32,
  parameter int unsigned OVR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  input  logic        clr_fault,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        period_start,
  output logic        fault
);

  localparam logic [11:0] DeadW  = 12'(DEADTIME);
  localparam logic [10:0] CntMax = 11'h7ff;

  logic [10:0] cnt_q, duty_lft_q, duty_rght_q;
  logic [10:0] duty_lft_in, duty_rght_in;
  logic [11:0] sum_lft, sum_rght;
  logic        wrap, past_dead, gate_off;
  logic        pwm1_lft_q, pwm2_lft_q, pwm1_rght_q, pwm2_rght_q, period_start_q;
  logic        pwm1_lft_d, pwm2_lft_d, pwm1_rght_d, pwm2_rght_d;

  assign wrap         = (cnt_q == CntMax);
  // Halve the signed speed and bias it to 50% duty.
  assign duty_lft_in  = {~lft_spd[11], lft_spd[10:1]};
  assign duty_rght_in = {~rght_spd[11], rght_spd[10:1]};
  assign sum_lft      = {1'b0, duty_lft_q} + DeadW;
  assign sum_rght     = {1'b0, duty_rght_q} + DeadW;
  assign past_dead    = ({1'b0, cnt_q} >= DeadW);

  always_comb begin
    pwm1_lft_d  = past_dead && (cnt_q < duty_lft_q) && !gate_off;
    pwm2_lft_d  = (sum_lft <= {1'b0, cnt_q}) && !gate_off;
    pwm1_rght_d = past_dead && (cnt_q < duty_rght_q) && !gate_off;
    pwm2_rght_d = (sum_rght <= {1'b0, cnt_q}) && !gate_off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_lft_q     <= 11'h400;
      duty_rght_q    <= 11'h400;
      pwm1_lft_q     <= 1'b0;
      pwm2_lft_q     <= 1'b0;
      pwm1_rght_q    <= 1'b0;
      pwm2_rght_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_q + 11'd1;
      if (wrap) begin
        duty_lft_q  <= duty_lft_in;
        duty_rght_q <= duty_rght_in;
      end
      pwm1_lft_q     <= pwm1_lft_d;
      pwm2_lft_q     <= pwm2_lft_d;
      pwm1_rght_q    <= pwm1_rght_d;
      pwm2_rght_q    <= pwm2_rght_d;
      period_start_q <= (cnt_q == 11'd0);
    end
  end

  assign PWM1_lft     = pwm1_lft_q;
  assign PWM2_lft     = pwm2_lft_q;
  assign PWM1_rght    = pwm1_rght_q;
  assign PWM2_rght    = pwm2_rght_q;
  assign period_start = period_start_q;

  logic unused_lsb;
  assign unused_lsb = lft_spd[0] ^ rght_spd[0];

`ifdef OVR_FAULT_EN
  typedef enum logic [0:0] {StRun, StFault} state_e;

  localparam logic [3:0] Limit = 4'(OVR_LIMIT);

  state_e     state_q, state_d;
  logic       seen_lft_q, seen_lft_d, seen_rght_q, seen_rght_d;
  logic [3:0] ocnt_lft_q, ocnt_lft_d, ocnt_rght_q, ocnt_rght_d;
  logic       hold_q, hold_d;
  logic       seen_lft, seen_rght, limit_hit;

  // Include this cycle's event so an over-current on the wrap cycle is not lost.
  assign seen_lft  = seen_lft_q | (OVR_I_lft & pwm1_lft_q);
  assign seen_rght = seen_rght_q | (OVR_I_rght & pwm1_rght_q);

  always_comb begin
    seen_lft_d  = seen_lft;
    seen_rght_d = seen_rght;
    ocnt_lft_d  = ocnt_lft_q;
    ocnt_rght_d = ocnt_rght_q;
    state_d     = state_q;
    hold_d      = hold_q && !wrap;
    if (wrap) begin
      seen_lft_d  = 1'b0;
      seen_rght_d = 1'b0;
      ocnt_lft_d  = !seen_lft ? 4'd0 : (ocnt_lft_q == 4'hf) ? 4'hf : ocnt_lft_q + 4'd1;
      ocnt_rght_d = !seen_rght ? 4'd0 : (ocnt_rght_q == 4'hf) ? 4'hf : ocnt_rght_q + 4'd1;
    end
    limit_hit = wrap && ((ocnt_lft_d >= Limit) || (ocnt_rght_d >= Limit));
    unique case (state_q)
      StRun: begin
        if (limit_hit) state_d = StFault;
      end
      StFault: begin
        if (clr_fault && !limit_hit) begin
          state_d     = StRun;
          seen_lft_d  = 1'b0;
          seen_rght_d = 1'b0;
          ocnt_lft_d  = '0;
          ocnt_rght_d = '0;
          // Keep the bridges off until the next period boundary.
          hold_d      = !wrap;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      seen_lft_q  <= 1'b0;
      seen_rght_q <= 1'b0;
      ocnt_lft_q  <= '0;
      ocnt_rght_q <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_lft_q  <= seen_lft_d;
      seen_rght_q <= seen_rght_d;
      ocnt_lft_q  <= ocnt_lft_d;
      ocnt_rght_q <= ocnt_rght_d;
      hold_q      <= hold_d;
    end
  end

  assign gate_off = (state_q == StFault) || hold_q;
  assign fault    = (state_q == StFault);
`else
  logic unused_ovr;
  assign unused_ovr = OVR_I_lft ^ OVR_I_rght ^ clr_fault;
  assign gate_off   = 1'b0;
  assign fault      = 1'b0;
`endif

endmodule
